// File: rtl/cover_pkg.sv
// Shared types and helpers for the toggle-cover collector: FSM state encoding
// and absolute cover-index arithmetic.
package cover_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } cover_state_t;

    localparam int COVER_INDEX_W = 64;

    function automatic logic [COVER_INDEX_W-1:0] cover_abs_index(
        input logic [COVER_INDEX_W-1:0] base,
        input logic [COVER_INDEX_W-1:0] ptr
    );
        return base + ptr;
    endfunction

endpackage

// File: rtl/cover_toggle_collector.sv
// Sticky toggle-cover hit bitmap with an on-demand drain that streams the
// absolute index of every hit point of a snapshot over a valid/ready port.
module cover_toggle_collector
    import cover_pkg::*;
#(
    parameter int WIDTH       = 58,
    parameter int COVER_INDEX = 0,
    parameter int COVER_TOTAL = 10906
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             valid,
    input  logic                         dump_req,
    output logic                         dump_busy,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [COVER_INDEX_W-1:0]     out_index,
    output logic                         done,
    output logic [$clog2(WIDTH+1)-1:0]   done_count,
    output cover_state_t                 dbg_state
);

    localparam int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [PTR_W-1:0]         LAST_PTR = PTR_W'(WIDTH - 1);
    localparam logic [COVER_INDEX_W-1:0] BASE     = COVER_INDEX_W'(COVER_INDEX);

    if (WIDTH < 1 || WIDTH > 4096) begin : g_width_err
        $error("cover_toggle_collector: WIDTH out of range 1..4096");
    end
    if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_range_err
        $error("cover_toggle_collector: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
    end

    logic [WIDTH-1:0]         r_live;
    logic [WIDTH-1:0]         r_shadow;
    logic [PTR_W-1:0]         r_ptr;
    logic [CNT_W-1:0]         r_count;
    cover_state_t             r_state;
    logic                     r_out_valid;
    logic [COVER_INDEX_W-1:0] r_out_index;
    logic                     r_done;
    logic [CNT_W-1:0]         r_done_count;
    logic                     w_last;

    assign w_last = (r_ptr == LAST_PTR);

    // Output port: record is held stable in EMIT until out_valid & out_ready
    // coincide on a rising edge; out_index reads 0 whenever out_valid is low.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_live       <= '0;
            r_shadow     <= '0;
            r_ptr        <= '0;
            r_count      <= '0;
            r_state      <= IDLE;
            r_out_valid  <= 1'b0;
            r_out_index  <= '0;
            r_done       <= 1'b0;
            r_done_count <= '0;
        end else begin
            r_live <= r_live | valid;
            case (r_state)
                IDLE: begin
                    if (dump_req) begin
                        // Request-cycle hits belong to the next snapshot only.
                        r_shadow <= r_live;
                        r_live   <= valid;
                        r_ptr    <= '0;
                        r_count  <= '0;
                        r_state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (r_shadow[r_ptr]) begin
                        r_out_valid <= 1'b1;
                        r_out_index <= cover_abs_index(BASE, COVER_INDEX_W'(r_ptr));
                        r_state     <= EMIT;
                    end else if (w_last) begin
                        r_done       <= 1'b1;
                        r_done_count <= r_count;
                        r_state      <= DONE;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                EMIT: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_index <= '0;
                        r_count     <= r_count + 1'b1;
                        if (w_last) begin
                            r_done       <= 1'b1;
                            r_done_count <= r_count + 1'b1;
                            r_state      <= DONE;
                        end else begin
                            r_ptr   <= r_ptr + 1'b1;
                            r_state <= SCAN;
                        end
                    end
                end
                DONE: begin
                    r_done       <= 1'b0;
                    r_done_count <= '0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dump_busy  = (r_state != IDLE);
    assign out_valid  = r_out_valid;
    assign out_index  = r_out_index;
    assign done       = r_done;
    assign done_count = r_done_count;
    assign dbg_state  = r_state;

endmodule

// File: doc/cover_toggle_collector.md
Name: cover_toggle_collector

Overview:
Synthesizable receiving end of the toggle-cover interface, for FPGA/emulation builds where the DPI cover hook is unavailable. Latches a WIDTH-bit valid vector into a sticky hit bitmap. On request, drains a snapshot of the bitmap as a stream of absolute cover indices over a valid/ready handshake. A host-side reader or trace DMA consumes the stream. Sits beside each toggle-cover instance, or behind a concatenated valid bus.

Parameters:
WIDTH, 58, number of cover points (valid bits); legal range 1..4096.
COVER_INDEX, 0, absolute index of bit 0.
COVER_TOTAL, 10906, global cover-point count; elaboration error if COVER_INDEX+WIDTH > COVER_TOTAL.

Ports:
clock  input  1  sole clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
valid  input  WIDTH  per-point hit pulses, sampled every cycle.
dump_req  input  1  start a drain; honoured only in IDLE.
dump_busy  output  1  high in every state except IDLE.
out_valid  output  1  record available.
out_ready  input  1  consumer accepts record.
out_index  output  64  absolute cover index, COVER_INDEX + bit position.
done  output  1  one-cycle pulse at end of drain.
done_count  output  $clog2(WIDTH+1)  number of records emitted this drain; valid when done=1.

Behaviour:
- Reset, synchronous, active-high, takes priority over everything:
  - live bitmap, shadow bitmap, ptr and count clear to 0; state goes to IDLE.
  - All outputs are 0.
  - valid is ignored in any cycle where reset=1.
  - Reset mid-drain abandons the drain: no done pulse, and pending records are lost.
- Live bitmap: live[i] <= live[i] | valid[i] every non-reset cycle. A hit is visible one cycle after valid.
- State IDLE, on dump_req=1:
  - shadow <= live.
  - live <= valid; hits in the request cycle go only to the new live bitmap, never to the snapshot.
  - ptr <= 0, count <= 0, state goes to SCAN.
- State SCAN, one bit examined per cycle:
  - If shadow[ptr]=1, go to EMIT.
  - Else if ptr==WIDTH-1, go to DONE.
  - Else ptr++.
- State EMIT:
  - out_valid=1 and out_index=COVER_INDEX+ptr, both registered and stable until accepted.
  - On out_valid & out_ready: count++; then go to DONE if ptr==WIDTH-1, else ptr++ and go to SCAN.
  - out_ready low stalls indefinitely with no change to out_index.
- State DONE: done=1 and done_count=count for exactly one cycle, then go to IDLE.
- Ordering and count:
  - Records are emitted in ascending index order, one per set snapshot bit, with no duplicates.
  - An empty snapshot emits no records and produces done with done_count=0 after WIDTH+1 cycles.
- Latency: worst case per drain is about 2*WIDTH+1 cycles with out_ready tied high.
- dump_req while dump_busy=1 is ignored; it is neither queued nor an error.
- The live bitmap keeps accumulating throughout a drain.
- out_index is computed at 64-bit width with no wrap; the COVER_TOTAL check guarantees range.
- out_index is 0 whenever out_valid=0.

Decomposition:
- Shared package cover_pkg holds:
  - state enum {IDLE, SCAN, EMIT, DONE};
  - localparam COVER_INDEX_W=64;
  - function cover_abs_index(base, ptr).
- No sub-module. Bitmap, FSM and output register live in one module; expected size about 150 lines.

Test Plan:
- Reset, then valid[3] and valid[40] pulsed once; dump_req; out_ready=1 -> records 3 then 40 (COVER_INDEX=0); done with done_count=2; dump_busy low afterwards.
- COVER_INDEX=1000, valid=all-ones for 1 cycle, dump -> 58 records with indices 1000..1057 in order; done_count=58.
- No hits, dump_req -> no out_valid; done pulse with done_count=0 exactly WIDTH+1 cycles after dump_req.
- valid[5] asserted in the same cycle as dump_req, with live previously holding bit 7 -> this drain emits only 7; a second dump emits only 5.
- out_ready held low 10 cycles during EMIT of index 12 -> out_valid and out_index stay 12 throughout; record emitted once after out_ready rises.
- reset asserted while in EMIT -> next cycle out_valid=0, dump_busy=0, no done pulse; a following dump emits nothing.
- dump_req pulsed repeatedly mid-drain -> ignored; exactly one done pulse.
